xdma_dsc_gen: RTL and testbench
===============================

Name: xdma_dsc_gen

Overview:
- Parametrised successor to the fixed-direction XDMA descriptor shims.
- Accepts one 104-bit transfer command per AXI-Stream beat. Splits it into one or more XDMA descriptors of at most MAX_CHUNK bytes each.
- Issues each descriptor with a proper load/ready handshake, within an outstanding-descriptor credit limit.
- Sits between the host-command FIFO and the XDMA descriptor-bypass port. One instance per C2H or H2C channel.

Parameters:
- DIRECTION, 0, 0 = C2H (address driven on dsc_dst_addr), 1 = H2C (address driven on dsc_src_addr).
- MAX_CHUNK, 32'h0001_0000, maximum bytes per descriptor; power of two, at least 64, at most 2^23.
- MAX_OUTSTANDING, 8, maximum issued-but-not-completed descriptors; range 1..255.
- CNT_W, 8, width of the outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  sole clock
- resetn  in  1  synchronous reset, active low
- S_AXIS_tdata  in  104  [95:32] host address; [22:0] byte length; other bits ignored
- S_AXIS_tvalid  in  1  command valid
- S_AXIS_tready  out  1  command accepted when tvalid && tready
- dsc_ready  in  1  XDMA can take a descriptor
- dsc_load  out  1  descriptor transferred this cycle
- dsc_ctl  out  16  always 0
- dsc_src_addr  out  64  H2C: chunk address; C2H: 0
- dsc_dst_addr  out  64  C2H: chunk address; H2C: 0
- dsc_len  out  28  chunk byte length, zero-extended
- dsc_done  in  1  one-cycle pulse per completed descriptor
- busy  out  1  state != IDLE or outstanding != 0
- err_underflow  out  1  sticky; set by dsc_done when outstanding == 0

Behaviour:
- Reset (resetn sampled low on a clk edge) clears all state:
  - state = IDLE; outstanding = 0; err_underflow = 0; address/remaining registers = 0.
  - S_AXIS_tready = 0 during reset, 1 in the first cycle after.
  - dsc_load = 0. Reset mid-transfer discards the remaining chunks.
- State machine IDLE / ISSUE:
  - IDLE: S_AXIS_tready = 1. On accept, latch addr = tdata[95:32] and rem = tdata[22:0].
    - rem == 0: command consumed, no descriptor, stay IDLE.
    - Otherwise go to ISSUE next cycle.
  - ISSUE: S_AXIS_tready = 0.
    - chunk = min(rem, MAX_CHUNK), combinational from registers.
    - dsc_load = dsc_ready && (outstanding < MAX_OUTSTANDING), combinational.
    - On dsc_load: addr += chunk (64-bit, wraps modulo 2^64); rem -= chunk. If rem == chunk, go to IDLE.
- Latency:
  - Command accept to first dsc_load: minimum 1 cycle.
  - Chunks are issued back-to-back, one per cycle, while dsc_ready is high and credits are available.
- Descriptor fields hold stable while in ISSUE and dsc_load is low. Outside ISSUE, dsc_len and addresses read 0.
- Outstanding counter:
  - +1 on dsc_load; -1 on dsc_done.
  - Simultaneous dsc_load and dsc_done: unchanged.
  - dsc_done with outstanding == 0 (and no simultaneous load): counter stays 0, err_underflow set.
- dsc_ready low for any duration stalls ISSUE without loss or duplication.
- Length 2^23-1 with MAX_CHUNK 2^16 yields 128 descriptors; the last is 65535 bytes.

Optional Feature:
- Macro: XDMA_DSC_GEN_STATS_EN.
- Defined:
  - Adds outputs stat_cmds (32-bit, commands accepted with length != 0) and stat_dscs (32-bit, dsc_load count).
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package xdma_dsc_pkg holds:
  - command field bit positions (ADDR_LSB = 32, ADDR_MSB = 95, LEN_MSB = 22);
  - DIR_C2H / DIR_H2C constants;
  - the state enum.
- One sub-module: xdma_dsc_credit, the outstanding counter with credit_ok and underflow flag. It is reusable by other DMA engines.

Test Plan:
- C2H, MAX_CHUNK = 64K; command addr 0x1_0000_0000, len 0x30000; dsc_ready held 1 -> 3 consecutive loads, dst_addr 0x1_0000_0000 / 0x1_0001_0000 / 0x1_0002_0000, each len 0x10000; src_addr 0.
- H2C, command len 0x100 -> single load, src_addr = command address, len 0x100, dst 0; then busy stays 1 until one dsc_done pulse.
- Command len 0 -> tready 1, no dsc_load ever; next command accepted the following cycle.
- MAX_OUTSTANDING = 2, len 0x40000, no dsc_done -> exactly 2 loads then stall; one dsc_done pulse -> third load next cycle.
- dsc_ready toggles 1,0,0,1 mid-transfer -> fields stable while stalled; total bytes across loads equals command len; no duplicate addresses.
- Reset asserted in ISSUE after 1 of 4 chunks -> dsc_load 0 and outstanding 0 after reset; extra dsc_done then sets err_underflow.

Source files
------------

// File: rtl/xdma_dsc_gen_pkg.sv
// rtl/xdma_dsc_gen_pkg.sv - shared constants and state type for the XDMA descriptor generator
//
// Package xdma_dsc_pkg: command field positions inside the 104-bit command
// beat, direction selectors, and the generator state enum. No ports.
package xdma_dsc_pkg;

  localparam int CMD_W    = 104;
  localparam int ADDR_LSB = 32;
  localparam int ADDR_MSB = 95;
  localparam int LEN_MSB  = 22;

  localparam int DIR_C2H = 0;
  localparam int DIR_H2C = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/xdma_dsc_gen_if.sv
// rtl/xdma_dsc_gen_if.sv - XDMA descriptor-bypass port bundle
//
// Signals:
//   dsc_ready     XDMA can take a descriptor
//   dsc_load      descriptor transferred this cycle
//   dsc_ctl       control word (driven 0)
//   dsc_src_addr  source address (H2C chunk address)
//   dsc_dst_addr  destination address (C2H chunk address)
//   dsc_len       chunk byte length
//   dsc_done      one-cycle pulse per completed descriptor
// Modports: master = descriptor generator, slave = XDMA side.
interface xdma_dsc_gen_if;

  logic        dsc_ready;
  logic        dsc_load;
  logic [15:0] dsc_ctl;
  logic [63:0] dsc_src_addr;
  logic [63:0] dsc_dst_addr;
  logic [27:0] dsc_len;
  logic        dsc_done;

  modport master (
    input  dsc_ready, dsc_done,
    output dsc_load, dsc_ctl, dsc_src_addr, dsc_dst_addr, dsc_len
  );

  modport slave (
    output dsc_ready, dsc_done,
    input  dsc_load, dsc_ctl, dsc_src_addr, dsc_dst_addr, dsc_len
  );

endinterface

// File: rtl/xdma_dsc_credit.sv
// rtl/xdma_dsc_credit.sv - outstanding-descriptor credit counter
//
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   inc          one descriptor issued this cycle
//   dec          one descriptor completed this cycle
//   count        issued-but-not-completed descriptors
//   credit_ok    count below MAX_OUTSTANDING, another issue is allowed
//   underflow    sticky: a completion arrived with nothing outstanding
module xdma_dsc_credit #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             credit_ok,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_OUTSTANDING);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: count <= count + CNT_W'(1);
        2'b01: begin
          // A stray completion never wraps the counter; it is only flagged.
          if (count == '0) underflow <= 1'b1;
          else             count     <= count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign credit_ok = (count < LIMIT);

endmodule

// File: rtl/xdma_dsc_gen.sv
// rtl/xdma_dsc_gen.sv - splits transfer commands into XDMA bypass descriptors
//
// Optional feature macro: XDMA_DSC_GEN_STATS_EN (adds stat_cmds / stat_dscs).
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   S_AXIS_tdata      command: [95:32] host address, [22:0] byte length
//   S_AXIS_tvalid     command valid
//   S_AXIS_tready     command accepted when tvalid && tready
//   dsc               descriptor-bypass port (xdma_dsc_gen_if.master)
//   busy              a command is being split or descriptors are outstanding
//   err_underflow     sticky: dsc_done seen with nothing outstanding
//   stat_cmds         (macro only) non-empty commands accepted
//   stat_dscs         (macro only) descriptors loaded
module xdma_dsc_gen
  import xdma_dsc_pkg::*;
#(
  parameter int          DIRECTION       = DIR_C2H,
  parameter logic [31:0] MAX_CHUNK       = 32'h0001_0000,
  parameter int          MAX_OUTSTANDING = 8,
  parameter int          CNT_W           = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CMD_W-1:0]  S_AXIS_tdata,
  input  logic              S_AXIS_tvalid,
  output logic              S_AXIS_tready,
  xdma_dsc_gen_if.master    dsc,
  output logic              busy,
  output logic              err_underflow
`ifdef XDMA_DSC_GEN_STATS_EN
  ,
  output logic [31:0]       stat_cmds,
  output logic [31:0]       stat_dscs
`endif
);

  state_e           state, state_nxt;
  logic [63:0]      addr, addr_nxt;
  logic [LEN_MSB:0] rem, rem_nxt;
  logic [LEN_MSB:0] chunk;
  logic             in_issue;
  logic             accept;
  logic             load;
  logic             credit_ok;
  logic [CNT_W-1:0] outstanding;

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{S_AXIS_tdata[CMD_W-1:ADDR_MSB+1], S_AXIS_tdata[ADDR_LSB-1:LEN_MSB+1]};

  // MAX_CHUNK may be 2^23, one bit wider than rem; the comparison is done at
  // 32 bits and the truncated MAX_CHUNK is only selected when rem exceeds it.
  assign chunk    = (32'(rem) > MAX_CHUNK) ? MAX_CHUNK[LEN_MSB:0] : rem;
  assign in_issue = (state == ST_ISSUE);

  assign S_AXIS_tready = resetn && (state == ST_IDLE);
  assign accept        = S_AXIS_tvalid && S_AXIS_tready;
  assign load          = resetn && in_issue && dsc.dsc_ready && credit_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
      addr  <= '0;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    rem_nxt   = rem;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          addr_nxt = S_AXIS_tdata[ADDR_MSB:ADDR_LSB];
          rem_nxt  = S_AXIS_tdata[LEN_MSB:0];
          // Zero-length commands are swallowed without leaving IDLE.
          if (S_AXIS_tdata[LEN_MSB:0] != '0) state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (load) begin
          addr_nxt = addr + 64'(chunk);
          rem_nxt  = rem - chunk;
          if (rem == chunk) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dsc.dsc_load = load;
  assign dsc.dsc_ctl  = '0;
  assign dsc.dsc_len  = in_issue ? 28'(chunk) : '0;

  if (DIRECTION == DIR_H2C) begin : g_h2c
    assign dsc.dsc_src_addr = in_issue ? addr : '0;
    assign dsc.dsc_dst_addr = '0;
  end else begin : g_c2h
    assign dsc.dsc_src_addr = '0;
    assign dsc.dsc_dst_addr = in_issue ? addr : '0;
  end

  xdma_dsc_credit #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_credit (
    .clk       (clk),
    .resetn    (resetn),
    .inc       (load),
    .dec       (dsc.dsc_done),
    .count     (outstanding),
    .credit_ok (credit_ok),
    .underflow (err_underflow)
  );

  assign busy = (state != ST_IDLE) || (outstanding != '0);

`ifdef XDMA_DSC_GEN_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_cmds <= '0;
      stat_dscs <= '0;
    end else begin
      if (accept && (S_AXIS_tdata[LEN_MSB:0] != '0)) stat_cmds <= stat_cmds + 32'd1;
      if (load) stat_dscs <= stat_dscs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xdma_dsc_gen.sv
// tb/tb_xdma_dsc_gen.sv - self-checking bench for xdma_dsc_gen (C2H and H2C instances)
`timescale 1ns/1ps
module tb_xdma_dsc_gen;
  import xdma_dsc_pkg::*;

  localparam int          BOUND = 3000;
  localparam logic [31:0] MC    = 32'h0001_0000;

  typedef struct {
    logic [63:0] addr;
    int          len;
  } chunk_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [103:0] tdata [2];
  logic         tvalid [2];
  logic         tready [2];
  logic         rdy [2];
  logic         done [2];
  logic         busy_o [2];
  logic         err_o [2];
  bit           rnd = 1'b0;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  xdma_dsc_gen_if dif [2] ();
  assign dif[0].dsc_ready = rdy[0];
  assign dif[0].dsc_done  = done[0];
  assign dif[1].dsc_ready = rdy[1];
  assign dif[1].dsc_done  = done[1];

`ifdef XDMA_DSC_GEN_STATS_EN
  logic [31:0] sc0, sd0, sc1, sd1;
`endif

  xdma_dsc_gen #(.DIRECTION(DIR_C2H), .MAX_CHUNK(MC), .MAX_OUTSTANDING(8), .CNT_W(8)) dut_c2h (
    .clk(clk), .resetn(resetn),
    .S_AXIS_tdata(tdata[0]), .S_AXIS_tvalid(tvalid[0]), .S_AXIS_tready(tready[0]),
    .dsc(dif[0]), .busy(busy_o[0]), .err_underflow(err_o[0])
`ifdef XDMA_DSC_GEN_STATS_EN
    , .stat_cmds(sc0), .stat_dscs(sd0)
`endif
  );

  xdma_dsc_gen #(.DIRECTION(DIR_H2C), .MAX_CHUNK(MC), .MAX_OUTSTANDING(2), .CNT_W(8)) dut_h2c (
    .clk(clk), .resetn(resetn),
    .S_AXIS_tdata(tdata[1]), .S_AXIS_tvalid(tvalid[1]), .S_AXIS_tready(tready[1]),
    .dsc(dif[1]), .busy(busy_o[1]), .err_underflow(err_o[1])
`ifdef XDMA_DSC_GEN_STATS_EN
    , .stat_cmds(sc1), .stat_dscs(sd1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model per instance: a queue of expected descriptors built from
  // each accepted command, plus an outstanding count and underflow flag.
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int MO  = (g == 0) ? 8 : 2;
    localparam bit H2C = (g == 1);
    chunk_t q[$];
    int     outst = 0;
    bit     uf = 1'b0;

    always @(negedge clk) begin
      chunk_t      h, nc;
      bit          issue, exp_load;
      logic [63:0] a;
      int          l, off, c;
      if (!resetn) begin
        chk($sformatf("i%0d_rst_tready", g), 64'(tready[g]), 64'd0);
        chk($sformatf("i%0d_rst_load", g), 64'(dif[g].dsc_load), 64'd0);
        q.delete();
        outst = 0;
        uf = 1'b0;
      end else begin
        issue = (q.size() != 0);
        if (issue) h = q[0];
        else begin h.addr = '0; h.len = 0; end
        exp_load = issue && (rdy[g] == 1'b1) && (outst < MO);
        chk($sformatf("i%0d_tready", g), 64'(tready[g]), 64'(!issue));
        chk($sformatf("i%0d_load", g), 64'(dif[g].dsc_load), 64'(exp_load));
        chk($sformatf("i%0d_busy", g), 64'(busy_o[g]), 64'(issue || outst != 0));
        chk($sformatf("i%0d_err", g), 64'(err_o[g]), 64'(uf));
        chk($sformatf("i%0d_len", g), 64'(dif[g].dsc_len), 64'(h.len));
        chk($sformatf("i%0d_src", g), dif[g].dsc_src_addr, H2C ? h.addr : 64'd0);
        chk($sformatf("i%0d_dst", g), dif[g].dsc_dst_addr, H2C ? 64'd0 : h.addr);
        chk($sformatf("i%0d_ctl", g), 64'(dif[g].dsc_ctl), 64'd0);
        if (exp_load) void'(q.pop_front());
        if (exp_load && !done[g]) outst++;
        else if (!exp_load && done[g]) begin
          if (outst == 0) uf = 1'b1;
          else outst--;
        end
        if (tvalid[g] && !issue) begin
          a = tdata[g][95:32];
          l = 32'(tdata[g][22:0]);
          off = 0;
          while (off < l) begin
            c = (l - off > int'(MC)) ? int'(MC) : l - off;
            nc.addr = a + 64'(off);
            nc.len = c;
            q.push_back(nc);
            off += c;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) begin
      for (int i = 0; i < 2; i++) begin
        rdy[i]  = ($urandom_range(0, 3) != 0);
        done[i] = ($urandom_range(0, 1) == 1);
      end
    end else begin
      done[0] = 1'b0;
      done[1] = 1'b0;
    end
  endtask

  task automatic send_cmd(input int g, input logic [63:0] a, input int len, output int waits);
    bit ok = 1'b0;
    tdata[g] = {8'($urandom), a, 9'($urandom), 23'(len)};
    tvalid[g] = 1'b1;
    waits = 0;
    for (int i = 0; i < BOUND && !ok; i++) begin
      @(negedge clk);
      ok = tready[g];
      if (!ok) waits++;
      tick();
    end
    tvalid[g] = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input int g);
    bit ok = 1'b0;
    for (int i = 0; i < BOUND && !ok; i++) begin
      if (tready[g]) ok = 1'b1;
      else tick();
    end
    if (!ok) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  // With dsc_ready held high, a completion pulse never underflows: either
  // descriptors are outstanding or a load happens in the same cycle.
  task automatic drain(input int g);
    bit ok = 1'b0;
    rdy[g] = 1'b1;
    for (int i = 0; i < BOUND && !ok; i++) begin
      if (!busy_o[g]) ok = 1'b1;
      else begin
        done[g] = 1'b1;
        tick();
      end
    end
    if (!ok) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w, g, pick, len;
    logic [63:0] a;
    for (int i = 0; i < 2; i++) begin
      tdata[i] = '0; tvalid[i] = 1'b0; rdy[i] = 1'b0; done[i] = 1'b0;
    end
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_tready", 64'(tready[0]), 64'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("post_rst_tready", 64'(tready[0]), 64'd1);
    chk("post_rst_busy", 64'(busy_o[1]), 64'd0);
    chk("post_rst_err", 64'(err_o[1]), 64'd0);

    // C2H: three full chunks back-to-back
    rdy[0] = 1'b1;
    send_cmd(0, 64'h1_0000_0000, 32'h30000, w);
    wait_idle(0);
    chk("c2h_outstanding_busy", 64'(busy_o[0]), 64'd1);
    drain(0);
    chk("c2h_drained", 64'(busy_o[0]), 64'd0);

    // H2C single descriptor, busy until its completion
    rdy[1] = 1'b1;
    send_cmd(1, 64'hDEAD_BEEF_0000_1000, 32'h100, w);
    wait_idle(1);
    repeat (3) tick();
    chk("h2c_busy_hold", 64'(busy_o[1]), 64'd1);
    done[1] = 1'b1;
    tick();
    chk("h2c_busy_clear", 64'(busy_o[1]), 64'd0);

    // Zero-length command, next command accepted immediately
    send_cmd(0, 64'h1234, 0, w);
    chk("len0_tready", 64'(tready[0]), 64'd1);
    send_cmd(0, 64'h5000, 32'h40, w);
    chk("len0_next_wait", 64'(w), 64'd0);
    wait_idle(0);
    drain(0);

    // Credit limit 2: stall after two loads, resume one cycle after a completion
    rdy[1] = 1'b1;
    send_cmd(1, 64'h8000_0000, 32'h40000, w);
    repeat (6) tick();
    chk("cred_stall_issue", 64'(tready[1]), 64'd0);
    chk("cred_stall_load", 64'(dif[1].dsc_load), 64'd0);
    done[1] = 1'b1;
    tick();
    chk("cred_third_load", 64'(dif[1].dsc_load), 64'd1);
    drain(1);

    // dsc_ready 1,0,0,1 mid-transfer, address wraps past 2^64
    rdy[0] = 1'b0;
    send_cmd(0, 64'hFFFF_FFFF_FFFE_0000, 32'h40000, w);
    rdy[0] = 1'b1; tick();
    rdy[0] = 1'b0; tick(); tick();
    rdy[0] = 1'b1;
    wait_idle(0);
    drain(0);

    // Randomized commands with random ready / completion traffic
    rnd = 1'b1;
    for (int n = 0; n < 30; n++) begin
      g = $urandom_range(0, 1);
      pick = $urandom_range(0, 3);
      case (pick)
        0: len = 0;
        1: len = $urandom_range(1, 32'h200);
        2: len = $urandom_range(1, 32'h40000);
        default: len = $urandom_range(1, 6) * 32'h10000;
      endcase
      if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_0000 + 64'($urandom_range(0, 32'hFFFF));
      else a = {$urandom, $urandom};
      send_cmd(g, a, len, w);
    end
    send_cmd(0, {$urandom, $urandom}, 32'h7F_FFFF, w);
    rnd = 1'b0;
    drain(0);
    drain(1);

    // Reset while issuing: remaining chunks discarded, credits cleared
    rdy[0] = 1'b0;
    send_cmd(0, 64'h4000_0000, 32'h40000, w);
    rdy[0] = 1'b1; tick();
    rdy[0] = 1'b0; tick();
    chk("rst_mid_issue", 64'(tready[0]), 64'd0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rst_mid_load", 64'(dif[0].dsc_load), 64'd0);
    chk("rst_mid_busy", 64'(busy_o[0]), 64'd0);
    chk("rst_mid_err", 64'(err_o[0]), 64'd0);
    done[0] = 1'b1;
    tick();
    chk("rst_uf_set", 64'(err_o[0]), 64'd1);
    tick();
    chk("rst_uf_sticky", 64'(err_o[0]), 64'd1);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
